// File: rtl/event_info_buffer.sv
// Event record builder: per-event {event number, trigger pattern[, timestamp]} queued in a FWFT FIFO.
// Optional timestamp field enabled by defining EVENT_INFO_TIMESTAMP_EN.
module event_info_buffer #(
    parameter int NUM_TRIGGERS = 4,
    parameter int EVCNT_WIDTH  = 16,
    parameter int TS_WIDTH     = 32,
    parameter int DEPTH_LOG2   = 4,
`ifdef EVENT_INFO_TIMESTAMP_EN
    localparam int DATA_W      = EVCNT_WIDTH + NUM_TRIGGERS + TS_WIDTH
`else
    localparam int DATA_W      = EVCNT_WIDTH + NUM_TRIGGERS
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    event_flag_i,
    input  logic [NUM_TRIGGERS-1:0] trig_flag_i,
    output logic [DATA_W-1:0]       dat_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DEPTH_LOG2:0]     count_o,
    output logic                    full_o,
    output logic [7:0]              drop_cnt_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (NUM_TRIGGERS < 1 || EVCNT_WIDTH < 1 || TS_WIDTH < 1 || DEPTH_LOG2 < 1) begin : g_bad_cfg
        $error("event_info_buffer: all width parameters must be >= 1");
    end

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH_LOG2-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]          count_q, count_d;
    logic [7:0]                   drop_q, drop_d;
    logic [EVCNT_WIDTH-1:0]       evcnt_q, evcnt_d;
    logic [NUM_TRIGGERS-1:0]      acc_q, acc_d, pattern;
    logic [DATA_W-1:0]            record;
    logic                         pop, push, room;
`ifdef EVENT_INFO_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]          ts_q, ts_d;
`endif

    assign valid_o    = (count_q != '0);
    assign full_o     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign count_o    = count_q;
    assign drop_cnt_o = drop_q;
    assign dat_o      = mem_q[rd_ptr_q];

    always_comb begin
        pop     = valid_o && ready_i;
        // A full FIFO still has room if the head leaves in the same cycle
        room    = !full_o || pop;
        push    = event_flag_i && room;
        pattern = acc_q | trig_flag_i;
`ifdef EVENT_INFO_TIMESTAMP_EN
        record  = {evcnt_q, pattern, ts_q};
        ts_d    = ts_q + 1'b1;
`else
        record  = {evcnt_q, pattern};
`endif
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        evcnt_d  = evcnt_q;
        acc_d    = pattern;

        if (push) begin
            mem_d[wr_ptr_q] = record;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        if (event_flag_i) begin
            evcnt_d = evcnt_q + 1'b1;
            acc_d   = '0;
            if (!room && drop_q != 8'hFF)
                drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            evcnt_q  <= '0;
            acc_q    <= '0;
`ifdef EVENT_INFO_TIMESTAMP_EN
            ts_q     <= '0;
`endif
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            evcnt_q  <= evcnt_d;
            acc_q    <= acc_d;
`ifdef EVENT_INFO_TIMESTAMP_EN
            ts_q     <= ts_d;
`endif
        end
    end
endmodule

// File: tb/tb_event_info_buffer.sv
// Bench for event_info_buffer: directed table/sequences plus randomized traffic vs a queue model.
module tb_event_info_buffer;
    localparam int NT    = 4;
    localparam int EVW   = 16;
    localparam int TSW   = 32;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
`ifdef EVENT_INFO_TIMESTAMP_EN
    localparam int DW = EVW + NT + TSW;
`else
    localparam int DW = EVW + NT;
`endif

    logic          clk, rst_n, ev, rdy;
    logic [NT-1:0] trig;
    logic [DW-1:0] dat;
    logic          valid, full;
    logic [DL2:0]  count;
    logic [7:0]    drops;

    event_info_buffer #(.NUM_TRIGGERS(NT), .EVCNT_WIDTH(EVW), .TS_WIDTH(TSW), .DEPTH_LOG2(DL2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .event_flag_i(ev), .trig_flag_i(trig),
        .dat_o(dat), .valid_o(valid), .ready_i(rdy), .count_o(count),
        .full_o(full), .drop_cnt_o(drops));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queue of expected records
    logic [DW-1:0] mq[$];
    int            m_evnum, m_drop;
    longint        m_ts;
    logic [NT-1:0] m_acc;

    function automatic logic [DW-1:0] make_rec(int evnum, logic [NT-1:0] pat, longint ts);
        logic [EVW-1:0] e;
        e = EVW'(evnum);
`ifdef EVENT_INFO_TIMESTAMP_EN
        return {e, pat, TSW'(ts)};
`else
        return {e, pat};
`endif
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_evnum = 0; m_drop = 0; m_ts = 0; m_acc = '0;
    endtask

    task automatic model_step(logic e, logic [NT-1:0] t, logic r);
        bit pop, room;
        logic [DW-1:0] rec;
        pop  = (mq.size() > 0) && r;
        room = (mq.size() < DEPTH) || pop;
        rec  = make_rec(m_evnum, m_acc | t, m_ts);
        if (pop) void'(mq.pop_front());
        if (e) begin
            if (room) mq.push_back(rec);
            else if (m_drop < 255) m_drop++;
            m_evnum = (m_evnum + 1) % (1 << EVW);
            m_acc   = '0;
        end else begin
            m_acc = m_acc | t;
        end
        m_ts++;
    endtask

    task automatic check_model();
        chk("valid", 64'(valid), 64'(mq.size() > 0));
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("drops", 64'(drops), 64'(m_drop));
        if (mq.size() > 0) chk("dat", 64'(dat), 64'(mq[0]));
    endtask

    // Called at a negedge; applies inputs across one posedge and checks at the next negedge
    task automatic cycle(logic e, logic [NT-1:0] t, logic r);
        ev = e; trig = t; rdy = r;
        @(posedge clk);
        model_step(e, t, r);
        @(negedge clk);
        ev = 1'b0; trig = '0; rdy = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_clear();
        rst_n = 1'b1;
    endtask

    function automatic logic [EVW-1:0] head_ev();
        return dat[DW-1 -: EVW];
    endfunction
    function automatic logic [NT-1:0] head_pat();
        return dat[DW-EVW-1 -: NT];
    endfunction

    typedef struct {
        logic          ev;
        logic [NT-1:0] trig;
        logic          rdy;
        logic          exp_valid;
        int            exp_count;
        int            exp_evnum;
        logic [NT-1:0] exp_pat;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1, 0, 4'b0000};
        vecs[1] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1, 1, 4'b0000};
        vecs[2] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1, 2, 4'b0000};
        vecs[3] = '{1'b0, 4'b0101, 1'b1, 1'b0, 0, 0, 4'b0000};
        vecs[4] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1, 3, 4'b0111};
        vecs[5] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 4'b0000};

        ev = 1'b0; trig = '0; rdy = 1'b0; rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", 64'(valid), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_drops", 64'(drops), 0);
        chk("rst_dat", 64'(dat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Trigger at cycle 5 plus coincident trigger with event at cycle 9
        for (int k = 0; k < 10; k++)
            cycle(k == 9, (k == 5) ? 4'b0010 : ((k == 9) ? 4'b1000 : 4'b0000), 1'b0);
        chk("t1_valid", 64'(valid), 1);
        chk("t1_rec", 64'(dat), 64'(make_rec(0, 4'b1010, 9)));
        cycle(1'b0, '0, 1'b1);

        // Table: back-to-back events with ready held, then pattern accumulation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].ev, vecs[i].trig, vecs[i].rdy);
            chk("tbl_valid", 64'(valid), 64'(vecs[i].exp_valid));
            chk("tbl_count", 64'(count), 64'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                chk("tbl_evnum", 64'(head_ev()), 64'(vecs[i].exp_evnum));
                chk("tbl_pat", 64'(head_pat()), 64'(vecs[i].exp_pat));
            end
        end

        // 18 events into 16 slots, then drain and check numbering gap
        do_reset();
        for (int i = 0; i < 18; i++) cycle(1'b1, '0, 1'b0);
        chk("fill_count", 64'(count), 16);
        chk("fill_full", 64'(full), 1);
        chk("fill_drops", 64'(drops), 2);
        for (int i = 0; i < 16; i++) begin
            chk("drain_evnum", 64'(head_ev()), 64'(i));
            cycle(1'b0, '0, 1'b1);
        end
        chk("drain_empty", 64'(valid), 0);
        cycle(1'b1, '0, 1'b0);
        chk("gap_evnum", 64'(head_ev()), 18);

        // Full FIFO: event and pop together is accepted
        for (int i = 0; i < 15; i++) cycle(1'b1, '0, 1'b0);
        chk("full2_count", 64'(count), 16);
        cycle(1'b1, '0, 1'b1);
        chk("pushpop_count", 64'(count), 16);
        chk("pushpop_full", 64'(full), 1);
        chk("pushpop_drops", 64'(drops), 2);
        chk("pushpop_head", 64'(head_ev()), 19);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) cycle(1'b1, '0, 1'b0);
        chk("drop_sat", 64'(drops), 255);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(valid), 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_drops", 64'(drops), 0);
        chk("arst_full", 64'(full), 0);
        @(negedge clk);
        model_clear();
        rst_n = 1'b1;
        cycle(1'b1, '0, 1'b0);
        chk("arst_evnum", 64'(head_ev()), 0);
        chk("arst_rec", 64'(dat), 64'(make_rec(0, 4'b0000, 0)));

        // Randomized traffic with varying consumer pressure
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                logic          e, r;
                logic [NT-1:0] t;
                e = ($urandom_range(0, 2) == 0);
                t = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
                r = ($urandom_range(0, 3) < ph + 1);
                cycle(e, t, r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/event_info_buffer.md
# event_info_buffer

Downstream of the event/trigger flag generator: consumes its one-cycle `event_flag` and per-bit `trig_flag` pulses. For each event it builds a record holding the event number, the trigger pattern seen since the previous event and, optionally, a cycle timestamp. Records are queued in a small first-word-fall-through FIFO for the readout logic to drain over a valid/ready handshake.

## Interface
- `NUM_TRIGGERS`, 4, width of the trigger-flag vector.
- `EVCNT_WIDTH`, 16, event-number width.
- `TS_WIDTH`, 32, timestamp width (used only with the timestamp macro).
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 records.
- `clk_i`  in  1  clock; the only clock.
- `rst_n_i`  in  1  reset; asynchronous assert, active-low.
- `event_flag_i`  in  1  one-cycle event pulse.
- `trig_flag_i`  in  NUM_TRIGGERS  one-cycle per-trigger pulses.
- `dat_o`  out  DATA_W  head record, MSB to LSB: {event number, pattern, timestamp}.
  - DATA_W = EVCNT_WIDTH+NUM_TRIGGERS(+TS_WIDTH).
- `valid_o`  out  1  head record present.
- `ready_i`  in  1  consumer accepts the head record; a pop occurs when `valid_o && ready_i`.
- `count_o`  out  DEPTH_LOG2+1  FIFO occupancy.
- `full_o`  out  1  occupancy equals 2^DEPTH_LOG2.
- `drop_cnt_o`  out  8  saturating count of events lost to a full FIFO.

## Operation
- Reset (`rst_n_i` low) takes effect immediately. All of the following are zero:
  - `valid_o`, `count_o`, `full_o`, `drop_cnt_o`, `dat_o`;
  - event counter, pattern accumulator, timestamp counter, FIFO pointers.
- Timestamp counter: free-running, +1 per clock, wraps modulo 2^TS_WIDTH.
- Pattern accumulator:
  - every cycle, acc <= acc | trig_flag_i;
  - on an event cycle, acc <= 0.
- Record pattern: acc | trig_flag_i in the event cycle, so trigger flags coincident with the event belong to that event, not the next.
- Record timestamp: counter value in the event cycle.
- Record event number: event counter value in the event cycle.
- Event counter: +1 on every `event_flag_i`, including dropped events, so numbering gaps expose drops. Wraps modulo 2^EVCNT_WIDTH.
- Push: on `event_flag_i`, the record is written when there is room.
  - Room exists when the FIFO is not full, or is full and a pop happens in the same cycle.
  - With no room, the record is discarded and `drop_cnt_o` increments, saturating at 255.
  - The accumulator still clears and the event counter still increments.
- Pop: `dat_o` always shows the head record. `dat_o` holds when `valid_o=0`; its value is then don't-care.
- Push and pop in the same cycle: `count_o` is unchanged.
- Pointers: DEPTH_LOG2 bits, wrap naturally. Occupancy is tracked by a separate counter.
- `ready_i` while `valid_o=0`: no effect.

## Timing
- Event in cycle N into an empty FIFO:
  - `valid_o`=1 and `dat_o`=record in N+1;
  - `count_o`=1 in N+1.
- Pop in cycle N: the next record appears on `dat_o` in N+1, or `valid_o`=0 in N+1 if none remains.
- `full_o`, `count_o` and `drop_cnt_o` are registered and update in the cycle after the causing edge.
- Back-to-back events, one per cycle, are each recorded. Each gets its own event number and the pattern of its own cycle only (acc was cleared).
- Reset mid-operation: FIFO contents are lost. The first post-reset event is number 0 with timestamp equal to cycles since reset release.

## Configuration
- `EVENT_INFO_TIMESTAMP_EN` defined:
  - timestamp counter and TS field are present;
  - DATA_W = EVCNT_WIDTH+NUM_TRIGGERS+TS_WIDTH.
- Not defined:
  - no timestamp logic, TS_WIDTH ignored;
  - DATA_W = EVCNT_WIDTH+NUM_TRIGGERS;
  - all other behaviour identical.

## Test plan
- Reset release, then trig_flag=4'b0010 at cycle 5, trig_flag=4'b1000 together with event at cycle 9 -> valid_o at cycle 10, record {evnum=0, pattern=4'b1010, ts=9}.
- Three events on consecutive cycles, no trig flags, ready_i held 1 -> three records, evnum 0,1,2, pattern 0, ts increasing by 1; count_o never exceeds 1.
- ready_i=0 with 18 events at DEPTH_LOG2=4 -> count_o=16, full_o=1, drop_cnt_o=2. Draining 16 records then shows evnum 0..15; the next event gets evnum 18.
- FIFO full with event and pop in the same cycle -> record accepted, count_o stays 16, drop_cnt_o unchanged.
- 300 events into a full FIFO with ready_i=0 -> drop_cnt_o saturates at 255.
- Assert rst_n_i low mid-stream asynchronously, between clock edges -> valid_o, count_o and drop_cnt_o go to 0 without a clock edge. The next event gets evnum 0.
